// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared encodings for the multi-channel wave computer
package wavegen_pkg;
  localparam int LUT_AW = 12;
  localparam int LUT_DW = 10;
  typedef enum logic [1:0] {SINE = 2'd0, SQUARE = 2'd1, SAW = 2'd2, TRI = 2'd3} wave_t;
  typedef enum logic [1:0] {CFG_AMP = 2'd0, CFG_INC = 2'd1, CFG_LOAD = 2'd2, CFG_MODE = 2'd3} cfg_sel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/multi_wave_compute_if.sv
// multi_wave_compute_if: frame request, config and mixed-sample bus
interface multi_wave_compute_if #(
  parameter int NCH = 4,
  parameter int OW = 16
);
  logic sample_req;
  logic cfg_we;
  logic [$clog2(NCH)-1:0] cfg_ch;
  logic [1:0] cfg_sel;
  logic [15:0] cfg_data;
  logic busy;
  logic out_valid;
  logic signed [OW-1:0] out_sample;
  logic overrun;
  modport master (
    output sample_req, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input busy, out_valid, out_sample, overrun
  );
  modport slave (
    input sample_req, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output busy, out_valid, out_sample, overrun
  );
endinterface

// File: rtl/sinetable.sv
// sinetable: 4096-point signed sine lookup, half wave mirrored by the address MSB
module sinetable
  import wavegen_pkg::*;
(
  input logic [LUT_AW-1:0] addr,
  output logic signed [LUT_DW-1:0] data
);
  logic [10:0] y;
  logic [31:0] u;
  logic [31:0] den;
  logic [31:0] mag;
  // rational half-wave approximation; scale factors chosen so pi cancels out
  always_comb begin
    y = addr[10:0];
    u = {21'd0, y} * (32'd2048 - {21'd0, y});
    den = 32'd5242880 - u;
    mag = (32'd2044 * u + (den >> 1)) / den;
    data = addr[11] ? -LUT_DW'(mag) : LUT_DW'(mag);
  end
endmodule

// File: rtl/wave_shape_gen.sv
// wave_shape_gen: maps the top phase bits and a wave mode to a 10-bit signed sample
module wave_shape_gen
  import wavegen_pkg::*;
(
  input logic [LUT_AW-1:0] ph,
  input wave_t mode,
  output logic signed [LUT_DW-1:0] w
);
  logic signed [LUT_DW-1:0] sine;
  logic msb;
  logic [9:0] t;
  sinetable u_sine (.addr(ph), .data(sine));
  // select the requested shape; triangle folds around the phase MSB
  always_comb begin
    msb = ph[11];
    t = ph[10:1];
    w = mode == SINE ? sine
      : mode == SQUARE ? (msb ? -10'sd511 : 10'sd511)
      : mode == SAW ? {~msb, ph[10:2]}
      : (msb ? 10'(10'd511 - t) : 10'(t - 10'd512));
  end
endmodule

// File: rtl/multi_wave_compute.sv
// multi_wave_compute: time-multiplexed NCH-channel wave generator with saturated mix
module multi_wave_compute
  import wavegen_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW = 16,
  parameter int AW = 16,
  parameter int OW = 16
) (
  input logic clk,
  input logic reset_n,
  multi_wave_compute_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int KW = CW < 2 ? 2 : CW;
  localparam int MW = OW + CW + 1;
  localparam int PRW = AW + 10;
  localparam int SH = AW + 9 - OW;
  localparam logic signed [MW-1:0] SMAX = MW'((2 ** (OW - 1)) - 1);
  localparam logic signed [MW-1:0] SMIN = MW'(-(2 ** (OW - 1)));
  logic [PW-1:0] acc [NCH];
  logic [PW-1:0] inc [NCH];
  logic signed [AW-1:0] amp [NCH];
  wave_t mode [NCH];
  logic [NCH-1:0] en;
  state_t state, state_n;
  logic [KW-1:0] cnt, cnt_n;
  logic [CW-1:0] ch;
  logic start, issue;
  logic signed [LUT_DW-1:0] w, w1;
  logic signed [AW-1:0] amp1;
  logic signed [PRW-1:0] prod2;
  logic signed [OW-1:0] term, sat, out_sample;
  logic signed [MW-1:0] mix, mix_n;
  logic l1, l2, out_valid, overrun;
  assign ch = cnt[CW-1:0];
  assign bus.busy = state != IDLE;
  assign bus.out_valid = out_valid;
  assign bus.out_sample = out_sample;
  assign bus.overrun = overrun;
  wave_shape_gen u_shape (.ph(acc[ch][PW-1 -: LUT_AW]), .mode(mode[ch]), .w(w));
  // frame sequencing, S3 scaling and output saturation
  always_comb begin
    start = state == IDLE && bus.sample_req;
    issue = state == RUN;
    state_n = start ? RUN
      : (issue && cnt == KW'(NCH - 1)) ? DRAIN
      : (state == DRAIN && cnt == KW'(2)) ? IDLE
      : state;
    cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + KW'(1);
    term = OW'(prod2 >>> SH);
    mix_n = mix + MW'(term);
    sat = mix_n > SMAX ? OW'(SMAX) : mix_n < SMIN ? OW'(SMIN) : OW'(mix_n);
  end
  // state register and channel counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // per-channel config and phase advance; a same-cycle load overrides the increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
        amp[i] <= '0;
        mode[i] <= SINE;
      end
      en <= '0;
    end else begin
      if (issue && en[ch]) acc[ch] <= acc[ch] + inc[ch];
      if (bus.cfg_we && {1'b0, bus.cfg_ch} < (CW + 1)'(NCH))
        case (bus.cfg_sel)
          CFG_AMP: amp[bus.cfg_ch] <= AW'(bus.cfg_data);
          CFG_INC: inc[bus.cfg_ch] <= PW'(bus.cfg_data);
          CFG_LOAD: acc[bus.cfg_ch] <= PW'({bus.cfg_data, PW'(0)} >> 16);
          CFG_MODE: begin
            mode[bus.cfg_ch] <= wave_t'(bus.cfg_data[1:0]);
            en[bus.cfg_ch] <= bus.cfg_data[2];
          end
        endcase
    end
  // shared pipeline: S1 shape capture, S2 multiply, S3 accumulate and publish
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      w1 <= '0;
      amp1 <= '0;
      prod2 <= '0;
      l1 <= 1'b0;
      l2 <= 1'b0;
      mix <= '0;
      out_sample <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      w1 <= issue && en[ch] ? w : '0;
      amp1 <= amp[ch];
      prod2 <= PRW'(amp1) * PRW'(w1);
      l1 <= issue && cnt == KW'(NCH - 1);
      l2 <= l1;
      mix <= start ? '0 : mix_n;
      out_valid <= l2;
      if (l2) out_sample <= sat;
      overrun <= bus.sample_req && state != IDLE;
    end
endmodule

// File: tb/tb_multi_wave_compute.sv
// tb_multi_wave_compute: table vectors plus scoreboarded frames against a behavioural model
module tb_multi_wave_compute;
  logic clk;
  logic reset_n;
  int cyc;
  int total;
  int bad;
  multi_wave_compute_if #(.NCH(4), .OW(16)) bus ();
  multi_wave_compute #(.NCH(4), .PW(16), .AW(16), .OW(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {int exp; int tol; int cyc;} sb_t;
  typedef struct {int mode; int amp; int ph; int exp;} vec_t;
  sb_t sb[$];
  vec_t tv[14];
  int m_acc[4], m_amp[4], m_inc[4], m_mode[4];
  bit m_en[4];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, int act, int exp, int tol = 0);
    total++;
    if (act - exp > tol || exp - act > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  function automatic int wave(int mode, int p);
    int msb, t, x;
    real th;
    msb = (p >> 15) & 1;
    t = (p >> 5) & 1023;
    x = (p >> 6) & 511;
    th = 2.0 * 3.14159265358979 * real'((p >> 4) & 4095) / 4096.0;
    case (mode)
      0: return $rtoi($floor(511.0 * $sin(th) + 0.5));
      1: return msb != 0 ? -511 : 511;
      2: return msb != 0 ? x : x - 512;
      default: return msb != 0 ? 511 - t : t - 512;
    endcase
  endfunction

  function automatic void model_frame(output int e, output int tol);
    int s;
    s = 0;
    tol = 0;
    for (int c = 0; c < 4; c++)
      if (m_en[c]) begin
        s += (m_amp[c] * wave(m_mode[c], m_acc[c])) >>> 9;
        if (m_mode[c] == 0) tol += ((m_amp[c] < 0 ? -m_amp[c] : m_amp[c]) * 2) / 512 + 2;
        m_acc[c] = (m_acc[c] + m_inc[c]) & 'hffff;
      end
    e = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
  endfunction

  task automatic cfg(int ch, int sel, int data);
    bus.cfg_we = 1;
    bus.cfg_ch = 2'(ch);
    bus.cfg_sel = 2'(sel);
    bus.cfg_data = 16'(data);
    case (sel)
      0: m_amp[ch] = (data & 'hffff) >= 32768 ? (data & 'hffff) - 65536 : (data & 'hffff);
      1: m_inc[ch] = data & 'hffff;
      2: m_acc[ch] = data & 'hffff;
      default: begin
        m_mode[ch] = data & 3;
        m_en[ch] = ((data >> 2) & 1) != 0;
      end
    endcase
    tick();
    bus.cfg_we = 0;
  endtask

  task automatic wait_out();
    int n;
    sb_t e;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    else if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_sample", int'(bus.out_sample), e.exp, e.tol);
      chk("latency", cyc - e.cyc, 7);
      chk("no_x", int'($isunknown(bus.out_sample)), 0);
    end
    tick();
  endtask

  task automatic frame_exp(int exp, int tol);
    sb.push_back('{exp, tol, cyc});
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    wait_out();
  endtask

  task automatic frame();
    int e, t;
    model_frame(e, t);
    frame_exp(e, t);
  endtask

  task automatic quiet(string nm, int n);
    int hit;
    hit = 0;
    repeat (n) begin
      if (bus.out_valid || bus.busy) hit = 1;
      tick();
    end
    chk(nm, hit, 0);
  endtask

  initial begin
    int e, t;
    tv = '{
      '{1, 'h7fff, 'h0000, 32703}, '{1, 'h7fff, 'h8000, -32704}, '{1, 'h8000, 'h0000, -32704},
      '{2, 'h7fff, 'h0000, -32767}, '{2, 'h7fff, 'h7fc0, -64}, '{2, 'h7fff, 'hffc0, 32703},
      '{3, 'h7fff, 'h0000, -32767}, '{3, 'h7fff, 'h8000, 32703}, '{3, 'h0100, 'h2000, -128},
      '{0, 'h7fff, 'h0000, 0}, '{0, 'h7fff, 'h4000, 32703}, '{0, 'h0200, 'hc000, -511},
      '{0, 'h0200, 'h2000, 361}, '{1, 'h0000, 'h0000, 0}
    };
    cyc = 0;
    total = 0;
    bad = 0;
    bus.sample_req = 0;
    bus.cfg_we = 0;
    bus.cfg_ch = 0;
    bus.cfg_sel = 0;
    bus.cfg_data = 0;
    for (int c = 0; c < 4; c++) begin
      m_acc[c] = 0; m_amp[c] = 0; m_inc[c] = 0; m_mode[c] = 0; m_en[c] = 0;
    end
    reset_n = 0;
    tick(3);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sample", int'(bus.out_sample), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    reset_n = 1;
    tick(2);
    for (int i = 0; i < 14; i++) begin
      cfg(0, 3, 4 | tv[i].mode);
      cfg(0, 0, tv[i].amp);
      cfg(0, 2, tv[i].ph);
      frame_exp(tv[i].exp, 0);
    end
    cfg(0, 3, 4);
    cfg(0, 0, 'h7fff);
    cfg(0, 1, 'h0100);
    cfg(0, 2, 0);
    repeat (64) frame();
    for (int c = 0; c < 4; c++) begin
      cfg(c, 3, 4 | 1);
      cfg(c, 0, 'h7fff);
      cfg(c, 1, 0);
      cfg(c, 2, 0);
    end
    frame_exp(32767, 0);
    for (int c = 0; c < 4; c++) cfg(c, 0, 'h8000);
    frame_exp(-32768, 0);
    for (int c = 0; c < 4; c++) cfg(c, 3, 0);
    cfg(1, 3, 4 | 2);
    cfg(1, 0, 'h7fff);
    cfg(1, 1, 'hffff);
    cfg(1, 2, 'hffff);
    repeat (80) frame();
    model_frame(e, t);
    sb.push_back('{e, t, cyc});
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    chk("busy_after_req", int'(bus.busy), 1);
    tick();
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    chk("overrun_pulse", int'(bus.overrun), 1);
    tick();
    chk("overrun_clear", int'(bus.overrun), 0);
    wait_out();
    model_frame(e, t);
    sb.push_back('{e, t, cyc});
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    tick(6);
    bus.sample_req = 1;
    wait_out();
    bus.sample_req = 0;
    chk("overrun_at_fall", int'(bus.overrun), 1);
    chk("drop_at_fall", int'(bus.busy), 0);
    quiet("no_extra_frame", 10);
    frame();
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    tick(2);
    reset_n = 0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_sample", int'(bus.out_sample), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    for (int c = 0; c < 4; c++) begin
      m_acc[c] = 0; m_amp[c] = 0; m_inc[c] = 0; m_mode[c] = 0; m_en[c] = 0;
    end
    tick(2);
    reset_n = 1;
    quiet("no_out_after_rst", 12);
    frame();
    cfg(0, 3, 4 | 2);
    frame();
    cfg(0, 0, 'h7fff);
    frame();
    frame();
    cfg(0, 3, 0);
    cfg(2, 3, 4 | 3);
    cfg(2, 0, 'h7fff);
    cfg(2, 1, 'h1000);
    cfg(2, 2, 'h2000);
    sb.push_back('{-16384, 0, cyc});
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    tick(2);
    bus.cfg_we = 1;
    bus.cfg_ch = 2'd2;
    bus.cfg_sel = 2'd2;
    bus.cfg_data = 16'h0000;
    tick();
    bus.cfg_we = 0;
    wait_out();
    frame_exp(-32767, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
